// File: rtl/smart_cargo_scheduler_if.sv
// Request handshake bundle for smart_cargo_scheduler.
//   req_valid   : requester offers a transport request
//   req_origem  : pickup floor
//   req_destino : drop-off floor
//   req_ready   : scheduler can take the request this cycle
// master = requester side, slave = scheduler side.
interface smart_cargo_scheduler_if #(
  parameter int unsigned NUM_FLOORS = 8
);
  localparam int unsigned FW = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1;

  logic          req_valid;
  logic [FW-1:0] req_origem;
  logic [FW-1:0] req_destino;
  logic          req_ready;

  modport master (
    output req_valid,
    output req_origem,
    output req_destino,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_origem,
    input  req_destino,
    output req_ready
  );
endinterface

// File: rtl/smart_cargo_scheduler.sv
// Cargo lift scheduler: a FIFO of stops (pickup then drop-off per request) drives a small FSM
// that moves the cabin up/down, pulses load/unload at each stop and dwells before moving on.
// Ports:
//   clock, reset (async, active-low)
//   iniciar, emergencia : run enable / emergency stop levels
//   sensores            : one-hot floor sensors
//   req_if              : request handshake (slave modport)
//   motorSubindo/motorDescendo, coloca_objetos/tira_objetos : actuator commands
//   andarAtual, proxParada, temDestino, fila_count, fila_cheia, estado : status
module smart_cargo_scheduler #(
  parameter int unsigned NUM_FLOORS   = 8,
  parameter int unsigned QUEUE_DEPTH  = 8,
  parameter int unsigned DWELL_CYCLES = 100,
  localparam int unsigned FW = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1,
  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic                  emergencia,
  input  logic [NUM_FLOORS-1:0] sensores,
  smart_cargo_scheduler_if.slave req_if,
  output logic                  motorSubindo,
  output logic                  motorDescendo,
  output logic                  coloca_objetos,
  output logic                  tira_objetos,
  output logic [FW-1:0]         andarAtual,
  output logic [FW-1:0]         proxParada,
  output logic                  temDestino,
  output logic [CW-1:0]         fila_count,
  output logic                  fila_cheia,
  output logic [2:0]            estado
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);

  typedef enum logic [2:0] {
    StParado   = 3'd0,
    StDecide   = 3'd1,
    StSubindo  = 3'd2,
    StDescendo = 3'd3,
    StPorta    = 3'd4,
    StEmerg    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [FW-1:0]       fila_floor_q [QUEUE_DEPTH];
  logic                fila_orig_q  [QUEUE_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [FW-1:0]       andar_q, andar_d;
  logic [NUM_FLOORS-1:0] sens_prev_q;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic                served_q, served_d;  // load/unload pulse already issued for current head

  logic          accept, push, pop, dwell_done, tem_destino, head_orig;
  logic [FW-1:0] head_floor, sens_idx;

  assign req_if.req_ready = (CW'(QUEUE_DEPTH) - count_q) >= CW'(2);
  assign accept      = req_if.req_valid && req_if.req_ready;
  // Degenerate or out-of-range requests complete the handshake but enqueue nothing.
  assign push        = accept && (req_if.req_origem != req_if.req_destino) &&
                       (32'(req_if.req_origem) < NUM_FLOORS) &&
                       (32'(req_if.req_destino) < NUM_FLOORS);
  assign tem_destino = (count_q != '0);
  assign head_floor  = fila_floor_q[rd_ptr_q];
  assign head_orig   = fila_orig_q[rd_ptr_q];
  assign dwell_done  = (dwell_q == DW'(DWELL_CYCLES - 1));
  assign pop         = (state_q == StPorta) && dwell_done && !emergencia && tem_destino;

  always_comb begin
    count_d = count_q;
    if (push) count_d = count_d + CW'(2);
    if (pop)  count_d = count_d - CW'(1);
  end

  // Floor tracking: only a fresh, single-hot sensor pattern moves the registered floor.
  always_comb begin
    sens_idx = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (sensores[i]) sens_idx = FW'(i);
    end
    andar_d = andar_q;
    if ($onehot(sensores) && (sensores != sens_prev_q)) andar_d = sens_idx;
  end

  always_comb begin
    state_d = state_q;
    if (emergencia) begin
      state_d = StEmerg;
    end else begin
      unique case (state_q)
        StParado: if (iniciar && tem_destino) state_d = StDecide;
        StDecide: begin
          if (!tem_destino)                state_d = StParado;
          else if (head_floor > andar_q)   state_d = StSubindo;
          else if (head_floor < andar_q)   state_d = StDescendo;
          else                             state_d = StPorta;
        end
        StSubindo, StDescendo: if (andar_q == head_floor) state_d = StPorta;
        StPorta:  if (dwell_done) state_d = (count_d != '0) ? StDecide : StParado;
        StEmerg:  state_d = tem_destino ? StDecide : StParado;
        default:  state_d = StParado;
      endcase
    end
  end

  // Dwell counter freezes in EMERG (and on the edge entering it); any other exit clears it.
  always_comb begin
    dwell_d = dwell_q;
    if (state_q == StPorta) begin
      if (!emergencia) dwell_d = dwell_done ? '0 : dwell_q + DW'(1);
    end else if (state_q != StEmerg) begin
      dwell_d = '0;
    end
    served_d = served_q;
    if (pop)                      served_d = 1'b0;
    else if (state_q == StPorta)  served_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StParado;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      andar_q     <= '0;
      sens_prev_q <= '0;
      dwell_q     <= '0;
      served_q    <= 1'b0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        fila_floor_q[i] <= '0;
        fila_orig_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      andar_q     <= andar_d;
      sens_prev_q <= sensores;
      dwell_q     <= dwell_d;
      served_q    <= served_d;
      if (push) begin
        fila_floor_q[wr_ptr_q]          <= req_if.req_origem;
        fila_orig_q[wr_ptr_q]           <= 1'b1;
        fila_floor_q[wr_ptr_q + PW'(1)] <= req_if.req_destino;
        fila_orig_q[wr_ptr_q + PW'(1)]  <= 1'b0;
        wr_ptr_q                        <= wr_ptr_q + PW'(2);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Motors decode straight from the state register so reset drops them without a clock.
  assign motorSubindo   = (state_q == StSubindo);
  assign motorDescendo  = (state_q == StDescendo);
  assign coloca_objetos = (state_q == StPorta) && !served_q && head_orig;
  assign tira_objetos   = (state_q == StPorta) && !served_q && !head_orig;
  assign andarAtual     = andar_q;
  assign proxParada     = tem_destino ? head_floor : '0;
  assign temDestino     = tem_destino;
  assign fila_count     = count_q;
  assign fila_cheia     = (count_q == CW'(QUEUE_DEPTH));
  assign estado         = state_q;

endmodule
